// File: rtl/universal_shift_register.sv
// Parametrised storage/shift element: parallel load, logical/arithmetic shift,
// rotate and synchronous clear, with async active-low reset and clock enable.
module universal_shift_register #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SL_IN,
  input  logic             SR_IN,
  output logic [WIDTH-1:0] Q,
  output logic             SO_L,
  output logic             SO_R
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LSR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_ASR  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] lsr_val;
  logic [WIDTH-1:0] rol_val;
  logic [WIDTH-1:0] ror_val;
  logic [WIDTH-1:0] asr_val;

  // A single bit has no neighbours: shifts take the serial input, rotates and
  // arithmetic shift reproduce the bit itself.
  generate
    if (WIDTH == 1) begin : g_single
      assign shl_val = SL_IN;
      assign lsr_val = SR_IN;
      assign rol_val = q_q;
      assign ror_val = q_q;
      assign asr_val = q_q;
    end else begin : g_multi
      assign shl_val = {q_q[WIDTH-2:0], SL_IN};
      assign lsr_val = {SR_IN, q_q[WIDTH-1:1]};
      assign rol_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      assign ror_val = {q_q[0], q_q[WIDTH-1:1]};
      assign asr_val = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    // NOTE: default assignment first so every path drives q_d and no latch is inferred.
    q_d = q_q;
    if (EN) begin
      case (mode_e'(MODE))
        MODE_LOAD: q_d = D;
        MODE_SHL:  q_d = shl_val;
        MODE_LSR:  q_d = lsr_val;
        MODE_ROL:  q_d = rol_val;
        MODE_ROR:  q_d = ror_val;
        MODE_CLR:  q_d = RESET_VAL;
        MODE_ASR:  q_d = asr_val;
        default:   q_d = q_q;
      endcase
    end
  end

  // NOTE: non-blocking assignments for registered state avoid evaluation-order races.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  // Serial outputs expose the bit about to leave, so cascades add no latency.
  assign Q    = q_q;
  assign SO_L = q_q[WIDTH-1];
  assign SO_R = q_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register: an 8-bit instance,
// a cascaded pair of 4-bit instances and a 1-bit instance.
module tb_universal_shift_register;

  logic clk;
  logic rst_n;

  // 8-bit instance
  logic       en8, sl8, sr8;
  logic [2:0] mode8;
  logic [7:0] d8, q8;
  logic       sol8, sor8;

  // cascaded 4-bit pair
  logic       en4;
  logic [2:0] mode4;
  logic [3:0] d_lo, d_hi, q_lo, q_hi;
  logic       sol_lo, sor_lo, sol_hi, sor_hi, sl_lo;

  // 1-bit instance
  logic       en1, sl1, sr1;
  logic [2:0] mode1;
  logic [0:0] d1, q1;
  logic       sol1, sor1;

  int n_tests = 0;
  int n_fail  = 0;

  universal_shift_register #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
    .CLK(clk), .RST_N(rst_n), .EN(en8), .MODE(mode8), .D(d8),
    .SL_IN(sl8), .SR_IN(sr8), .Q(q8), .SO_L(sol8), .SO_R(sor8)
  );

  universal_shift_register #(.WIDTH(4)) u_lo (
    .CLK(clk), .RST_N(rst_n), .EN(en4), .MODE(mode4), .D(d_lo),
    .SL_IN(sl_lo), .SR_IN(1'b0), .Q(q_lo), .SO_L(sol_lo), .SO_R(sor_lo)
  );

  universal_shift_register #(.WIDTH(4)) u_hi (
    .CLK(clk), .RST_N(rst_n), .EN(en4), .MODE(mode4), .D(d_hi),
    .SL_IN(sol_lo), .SR_IN(1'b0), .Q(q_hi), .SO_L(sol_hi), .SO_R(sor_hi)
  );

  universal_shift_register #(.WIDTH(1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .EN(en1), .MODE(mode1), .D(d1),
    .SL_IN(sl1), .SR_IN(sr1), .Q(q1), .SO_L(sol1), .SO_R(sor1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] val);
    en8 = 1'b1; mode8 = 3'b001; d8 = val;
    tick();
  endtask

  logic [7:0] exp8;

  initial begin
    rst_n = 1'b1;
    en8 = 1'b0; mode8 = 3'b000; d8 = '0; sl8 = 1'b0; sr8 = 1'b0;
    en4 = 1'b0; mode4 = 3'b000; d_lo = '0; d_hi = '0; sl_lo = 1'b0;
    en1 = 1'b0; mode1 = 3'b000; d1 = '0; sl1 = 1'b0; sr1 = 1'b0;

    // Reset asserted between edges takes effect immediately.
    #2 rst_n = 1'b0;
    #1;
    check("rst_q",    q8,   32'hA5);
    check("rst_so_l", sol8, 32'h1);
    check("rst_so_r", sor8, 32'h1);
    check("rst_q1",   q1,   32'h0);
    en8 = 1'b1; mode8 = 3'b001; d8 = 8'hFF;
    repeat (3) tick();
    check("rst_hold_q", q8, 32'hA5);
    #3 rst_n = 1'b1;

    // Load, then hold with enable low.
    d8 = 8'h3C;
    tick();
    check("load_3c", q8, 32'h3C);
    en8 = 1'b0; d8 = 8'hFF;
    repeat (2) tick();
    check("en_low_hold", q8, 32'h3C);
    en8 = 1'b1; mode8 = 3'b000;
    tick();
    check("mode_hold", q8, 32'h3C);

    // Shifts
    load8(8'h81);
    check("load_81", q8, 32'h81);
    check("so_l_81", sol8, 32'h1);
    mode8 = 3'b010; sl8 = 1'b0;
    tick();
    check("shl_81", q8, 32'h02);
    load8(8'h81);
    mode8 = 3'b011; sr8 = 1'b1;
    tick();
    check("lsr_81", q8, 32'hC0);
    load8(8'h81);
    mode8 = 3'b111;
    tick();
    check("asr_81", q8, 32'hC0);
    load8(8'h01);
    mode8 = 3'b111;
    tick();
    check("asr_01", q8, 32'h00);

    // Rotates
    load8(8'h81);
    mode8 = 3'b100;
    tick();
    check("rol_81", q8, 32'h03);
    load8(8'h81);
    exp8 = 8'h81;
    mode8 = 3'b101;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ror_so_r_%0d", i), sor8, {31'b0, exp8[0]});
      tick();
      exp8 = {exp8[0], exp8[7:1]};
      check($sformatf("ror_q_%0d", i), q8, exp8);
    end
    check("ror_wrap", q8, 32'h81);

    // Synchronous clear
    load8(8'h5A);
    mode8 = 3'b110;
    tick();
    check("sync_clr", q8, 32'hA5);

    // Reset pulse in the middle of a shift sequence.
    load8(8'h5A);
    mode8 = 3'b010; sl8 = 1'b1;
    tick();
    check("shl_5a", q8, 32'hB5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_q", q8, 32'hA5);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_shl", q8, 32'h4B);
    en8 = 1'b0;

    // Cascade: low SO_L feeds high SL_IN.
    en4 = 1'b1; mode4 = 3'b001; d_lo = 4'h8; d_hi = 4'h0;
    tick();
    check("cas_load_lo", q_lo, 32'h8);
    check("cas_so_l_lo", sol_lo, 32'h1);
    mode4 = 3'b010; sl_lo = 1'b0;
    tick();
    check("cas_hi", q_hi, 32'h1);
    check("cas_lo", q_lo, 32'h0);
    check("cas_so_r_hi", sor_hi, 32'h1);
    en4 = 1'b0;

    // WIDTH=1 boundary
    en1 = 1'b1; mode1 = 3'b001; d1 = 1'b1;
    tick();
    check("w1_load", q1, 32'h1);
    mode1 = 3'b100;
    tick();
    check("w1_rol", q1, 32'h1);
    mode1 = 3'b101;
    tick();
    check("w1_ror", q1, 32'h1);
    mode1 = 3'b111;
    tick();
    check("w1_asr", q1, 32'h1);
    mode1 = 3'b011; sr1 = 1'b0;
    tick();
    check("w1_lsr", q1, 32'h0);
    check("w1_so_l", sol1, 32'h0);
    check("w1_so_r", sor1, 32'h0);
    mode1 = 3'b010; sl1 = 1'b1;
    tick();
    check("w1_shl", q1, 32'h1);
    check("w1_so_l_hi", sol1, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
